// File: rtl/sseg_scan.sv
// Seven-segment scan driver for the stopwatch: snapshots four BCD digits at frame
// boundaries and time-multiplexes them onto a 4-digit common-anode display as M.SS.t.
module sseg_scan #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_DARK = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [PW-1:0]   pre_q, pre_d;
    logic [1:0]      sel_q, sel_d;
    logic [3:0][3:0] snap_q, snap_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [3:0]      an_q, an_d;

    logic       strobe;
    logic       frame_end;
    logic [3:0] digit;
    logic       blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        s = SEG_DASH;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Timebase and snapshot next-state
    always_comb begin
        strobe    = (pre_q == PRE_MAX);
        frame_end = strobe && (sel_q == 2'd3);
        pre_d     = strobe ? '0 : pre_q + 1'b1;
        sel_d     = strobe ? sel_q + 2'd1 : sel_q;
        snap_d    = snap_q;
        // hold is only looked at here, so a hold pulse in the boundary cycle wins
        if (frame_end && !hold) begin
            snap_d = {d3, d2, d1, d0};
        end
    end

    // Output decode for the slot currently selected
    always_comb begin
        digit = snap_q[sel_q];
        blank = 1'b0;
        an_d  = 4'b1111;
        dp_d  = 1'b1;
        unique case (sel_q)
            2'd0: begin
                an_d = 4'b1110;
            end
            2'd1: begin
                an_d = 4'b1101;
                dp_d = 1'b0;
            end
            2'd2: begin
                an_d  = 4'b1011;
                blank = BLANK_LZ && (snap_q[3] == 4'd0) && (snap_q[2] == 4'd0);
            end
            2'd3: begin
                an_d  = 4'b0111;
                blank = BLANK_LZ && (snap_q[3] == 4'd0);
                dp_d  = 1'b0;
            end
            default: begin
                an_d = 4'b1111;
            end
        endcase
        seg_d = bcd_to_seg(digit);
        // A blanked slot keeps its anode active so every digit sees the same duty
        if (blank) begin
            seg_d = SEG_DARK;
            dp_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            sel_q  <= 2'd0;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_DARK;
            dp_q   <= 1'b1;
        end else begin
            pre_q  <= pre_d;
            sel_q  <= sel_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_sseg_scan.sv
// Randomized bench for sseg_scan: two instances (blanking on/off) compared each cycle
// against an arithmetic model built from cycle counts since reset release.
module tb_sseg_scan;

    localparam int unsigned DIV   = 4;
    localparam int unsigned FRAME = 4 * DIV;
    localparam logic [11:0] DARK  = 12'hFFF;

    localparam logic [6:0] SEG_TBL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b;
    logic [3:0] an_a, an_b;

    int vectors = 0;
    int miscompares = 0;

    sseg_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) u_dut_lz (
        .clk(clk), .reset_n(reset_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .hold(hold),
        .seg(seg_a), .dp(dp_a), .an(an_a)
    );

    sseg_scan #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .reset_n(reset_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .hold(hold),
        .seg(seg_b), .dp(dp_b), .an(an_b)
    );

    always #5 clk = ~clk;

    // Reference model: mk counts edges since reset release; the slot shown after edge
    // mk+1 is (mk / DIV) % 4, and capture happens on every FRAME-th edge.
    int unsigned mk;
    logic [15:0] ms;
    logic [11:0] exp_a, exp_b;

    function automatic logic [11:0] expect_out(input int unsigned pos, input logic [15:0] snap,
                                               input bit blank_en);
        logic [3:0] dig;
        logic [3:0] anv;
        logic [6:0] sg;
        logic       d;
        bit         blank;
        dig = snap[pos*4 +: 4];
        anv = 4'b1111;
        anv[pos] = 1'b0;
        sg = (dig <= 4'd9) ? SEG_TBL[dig] : 7'b0111111;
        d = (pos == 1 || pos == 3) ? 1'b0 : 1'b1;
        blank = blank_en && ((pos == 3 && snap[15:12] == 0) ||
                             (pos == 2 && snap[15:12] == 0 && snap[11:8] == 0));
        if (blank) begin
            sg = 7'b1111111;
            d = 1'b1;
        end
        return {anv, sg, d};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mk    <= 0;
            ms    <= '0;
            exp_a <= DARK;
            exp_b <= DARK;
        end else begin
            exp_a <= expect_out((mk / DIV) % 4, ms, 1'b1);
            exp_b <= expect_out((mk / DIV) % 4, ms, 1'b0);
            if (((mk + 1) % FRAME) == 0 && !hold) ms <= {d3, d2, d1, d0};
            mk <= mk + 1;
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        {d3, d2, d1, d0} = 16'h0000;
        hold = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {DARK, DARK}) begin
            miscompares++;
            $display("FAIL reset_dark: got %h/%h want %h", {an_a, seg_a, dp_a},
                     {an_b, seg_b, dp_b}, DARK);
        end
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({an_a, seg_a, dp_a} !== {4'b1110, 7'b1000000, 1'b1}) begin
            miscompares++;
            $display("FAIL startup_slot0: got %b want 1110_1000000_1", {an_a, seg_a, dp_a});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if ({an_a, seg_a, dp_a} !== {4'b1101, 7'b1000000, 1'b0}) begin
            miscompares++;
            $display("FAIL startup_slot1: got %b want 1101_1000000_0", {an_a, seg_a, dp_a});
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL startup_model: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] prev_an;
        int         run;
        bit         first_run;
        prev_an = an_a;
        run = 0;
        first_run = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an_a === prev_an) begin
                run++;
            end else begin
                vectors++;
                if ((!first_run && run != DIV - 1) ||
                    an_a !== {prev_an[2:0], prev_an[3]}) begin
                    miscompares++;
                    $display("FAIL scan_order: an %b -> %b after %0d cycles want %0d", prev_an,
                             an_a, run + 1, DIV);
                end
                first_run = 1'b0;
                run = 0;
                prev_an = an_a;
            end
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL scan_model: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_tearing();
        logic [7:0] want;
        for (int i = 0; i < FRAME && (mk % FRAME) != 6; i++) @(negedge clk);
        {d3, d2, d1, d0} = 16'h1234;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL tear_model: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
        end
        // Next frame is fully captured: check literal codes
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            case (an_a)
                4'b1110: want = {7'b0011001, 1'b1};
                4'b1101: want = {7'b0110000, 1'b0};
                4'b1011: want = {7'b0100100, 1'b1};
                4'b0111: want = {7'b1111001, 1'b0};
                default: want = 8'hxx;
            endcase
            vectors++;
            if ({seg_a, dp_a} !== want) begin
                miscompares++;
                $display("FAIL tear_literal: an=%b got %b want %b", an_a, {seg_a, dp_a}, want);
            end
        end
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'($urandom_range(1, FRAME)); i++) @(negedge clk);
            {d3, d2, d1, d0} = 16'($urandom);
            for (int i = 0; i < FRAME + int'($urandom_range(0, FRAME)); i++) begin
                @(negedge clk);
                vectors++;
                if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                    miscompares++;
                    $display("FAIL tear_random: mk=%0d got %h_%h want %h_%h", mk,
                             {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
                end
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] pats [6];
        pats[0] = 16'h0073;
        pats[1] = 16'h0473;
        pats[2] = 16'h1000;
        pats[3] = 16'h0009;
        pats[4] = {4'd0, 4'd0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        pats[5] = {4'd0, 4'($urandom_range(1, 5)), 4'($urandom_range(0, 9)), 4'd0};
        for (int p = 0; p < 6; p++) begin
            {d3, d2, d1, d0} = pats[p];
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                vectors++;
                if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                    miscompares++;
                    $display("FAIL blank_model: pat=%h mk=%0d got %h_%h want %h_%h", pats[p],
                             mk, {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
                end
            end
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL hold_frozen: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
            d0 = d0 + 4'd1;
            d1 = 4'($urandom_range(0, 9));
        end
        hold = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL hold_release: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
            d0 = d0 + 4'd1;
        end
        // hold asserted only for the boundary cycle
        for (int i = 0; i < FRAME && ((mk + 1) % FRAME) != 0; i++) @(negedge clk);
        hold = 1'b1;
        {d3, d2, d1, d0} = 16'h5987;
        @(negedge clk);
        hold = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL hold_boundary: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_error();
        {d3, d2, d1, d0} = {4'd2, 4'($urandom_range(0, 5)), 4'hC, 4'($urandom_range(10, 15))};
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL error_model: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
            if (i >= FRAME && an_a === 4'b1101) begin
                vectors++;
                if (seg_a !== 7'b0111111) begin
                    miscompares++;
                    $display("FAIL error_dash: got %b want 0111111", seg_a);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FRAME && (mk % DIV) != 1; i++) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {DARK, DARK}) begin
            miscompares++;
            $display("FAIL reset_async: got %h_%h want %h", {an_a, seg_a, dp_a},
                     {an_b, seg_b, dp_b}, DARK);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({an_a, seg_a, dp_a} !== {4'b1110, 7'b1000000, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_restart: got %b want 1110_1000000_1", {an_a, seg_a, dp_a});
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            vectors++;
            if ({an_a, seg_a, dp_a, an_b, seg_b, dp_b} !== {exp_a, exp_b}) begin
                miscompares++;
                $display("FAIL reset_model: mk=%0d got %h_%h want %h_%h", mk,
                         {an_a, seg_a, dp_a}, {an_b, seg_b, dp_b}, exp_a, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_blanking();
        test_hold();
        test_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sseg_scan.md
Name: sseg_scan

Overview:
- Downstream display stage of the stopwatch.
- Consumes the four BCD digits from the stopwatch counter and drives the Basys3 4-digit common-anode seven-segment display by time-multiplexing.
- Digit mapping: d3 = minutes, d2 = tens of seconds, d1 = seconds, d0 = tenths.
- Adds frame-boundary snapshotting (no tearing), lap-hold freeze, leading-zero blanking and decimal points, giving the format M.SS.t.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (100 MHz gives 1 kHz slot rate, 250 Hz frame). Must be >= 2. Prescaler width is clog2(REFRESH_DIV).
- BLANK_LZ, 1, 1 enables leading-zero blanking on d3/d2; 0 always shows all digits.

Ports:
- clk  input  1  system clock (100 MHz)
- reset_n  input  1  asynchronous, active-low reset
- d0  input  4  tenths digit, BCD
- d1  input  4  seconds digit, BCD
- d2  input  4  tens-of-seconds digit, BCD (0-5 nominal)
- d3  input  4  minutes digit, BCD
- hold  input  1  lap hold; 1 freezes the displayed value
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  4  digit anodes, active-low; an[0] = rightmost (d0)

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset (reset_n=0, asynchronous, any time including mid-frame):
  - prescaler=0, sel=0, snapshot s0..s3=0.
  - an=4'b1111, seg=7'b1111111, dp=1 immediately (display dark).
- Prescaler:
  - Counts 0..REFRESH_DIV-1. strobe=1 in the cycle where prescaler==REFRESH_DIV-1.
  - On that edge prescaler goes to 0 and sel increments. sel is 2-bit and wraps 3 to 0.
- Snapshot:
  - On a strobe edge with sel==3 (frame boundary) and hold==0, s0..s3 <= d0..d3.
  - With hold==1 the snapshot is held. Capture resumes at the first frame boundary after hold falls.
  - hold is sampled only at frame boundaries.
- Output register:
  - an/seg/dp are registered every clk from the current sel and snapshot, so outputs lag sel by exactly 1 cycle.
  - The first edge after reset release drives an=1110 with digit s0.
  - Each digit is therefore shown for REFRESH_DIV cycles.
  - Scan order: an = 1110, 1101, 1011, 0111, repeating.
- Decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10-15 display "-" (0111111) as an error indicator.
- Blanking (BLANK_LZ=1):
  - Position 3 is blank when s3==0.
  - Position 2 is blank when s3==0 and s2==0.
  - Positions 1 and 0 are never blanked.
  - A blank slot drives seg=1111111 and dp=1, but its anode is still driven low for that slot (uniform duty).
- Decimal points:
  - dp=0 on position 1 (seconds.tenths).
  - dp=0 on position 3 when not blanked.
  - dp=1 on positions 0 and 2.
- Simultaneous hold and frame boundary: hold==1 in the boundary cycle wins; no capture.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1 unless noted):
1. Reset and startup:
   - reset_n=0: an=1111, seg=1111111, dp=1.
   - Release with d=0,0,0,0: next edge an=1110 seg=1000000 dp=1. After 4 cycles an=1101 seg=1000000 dp=0. Positions 2 and 3 then dark.
2. Scan timing: 64 cycles free-running. Each an value is held exactly 4 cycles, in order 1110, 1101, 1011, 0111. 1 cycle latency from the sel change.
3. Snapshot tearing:
   - Set d3..d0=1,2,3,4 mid-frame. The current frame still shows the old values.
   - After the sel 3 to 0 boundary: 1110 gives 4 (0011001); 1101 gives 3 with dp=0; 1011 gives 2; 0111 gives 1 (1111001) with dp=0.
4. Leading-zero blanking:
   - d=0,0,7,3: positions 3 and 2 give seg=1111111 dp=1; 1101 gives 1111000 dp=0.
   - d=0,4,7,3: position 2 shows 0011001.
   - Rerun with BLANK_LZ=0: d=0,0,7,3 shows 0 on positions 3 and 2.
5. Hold:
   - hold=1 across two frames while d increments every cycle: seg pattern unchanged.
   - Drop hold: new values appear only after the next frame boundary.
   - hold=1 exactly in a boundary cycle: no capture.
6. Error and reset mid-frame:
   - d1=4'hC gives seg=0111111 at 1101.
   - Pull reset_n low mid-slot: outputs go dark asynchronously the same cycle. After release, scan restarts at an=1110 showing 0.
